// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-side stage between the multi-cycle control unit and
// an ack-based word memory. Issues bus transactions, stalls control until they
// complete, holds IR/MDR, and does lane steering, extension and alignment checks.
`timescale 1ns/1ps
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic        ior_d,
  input  logic        ir_wr,
  input  logic [31:0] pc,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        addr_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [7:0]  cnt_q, cnt_d;
  // Attributes of the in-flight access, needed when the read data returns.
  logic [1:0]  acc_sz_q, acc_sz_d;
  logic        acc_sext_q, acc_sext_d;
  logic [1:0]  acc_lo_q, acc_lo_d;
  logic        acc_fetch_q, acc_fetch_d;
  logic        acc_irwr_q, acc_irwr_d;

  logic [31:0] addr;
  logic [1:0]  sz;
  logic        sext;
  logic        req;
  logic        aligned;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] load_ext;

  // Decode access size/sign from the current opcode and check alignment.
  always_comb begin
    sz   = SZ_W;
    sext = 1'b0;
    addr = ior_d ? alu_addr : pc;
    req  = mem_rd | mem_wr;
    if (ior_d) begin
      case (ir_q[31:26])
        6'd32:   begin sz = SZ_B; sext = 1'b1; end
        6'd36:   sz = SZ_B;
        6'd33:   begin sz = SZ_H; sext = 1'b1; end
        6'd37:   sz = SZ_H;
        6'd40:   sz = SZ_B;
        6'd41:   sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end
    case (sz)
      SZ_B:    aligned = 1'b1;
      SZ_H:    aligned = ~addr[0];
      default: aligned = (addr[1:0] == 2'b00);
    endcase
  end

  // Store lane steering: replicate the low byte/half and enable the target lanes.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = store_data;
    case (sz)
      SZ_B: begin
        wr_be   = 4'b0001 << addr[1:0];
        wr_data = {4{store_data[7:0]}};
      end
      SZ_H: begin
        wr_be   = addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{store_data[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = store_data;
      end
    endcase
  end

  // Load extraction: select lane from the latched low address bits, then extend.
  always_comb begin
    load_ext = bus_rdata;
    case (acc_sz_q)
      SZ_B: begin
        case (acc_lo_q)
          2'd0:    load_ext = {{24{acc_sext_q & bus_rdata[7]}},  bus_rdata[7:0]};
          2'd1:    load_ext = {{24{acc_sext_q & bus_rdata[15]}}, bus_rdata[15:8]};
          2'd2:    load_ext = {{24{acc_sext_q & bus_rdata[23]}}, bus_rdata[23:16]};
          default: load_ext = {{24{acc_sext_q & bus_rdata[31]}}, bus_rdata[31:24]};
        endcase
      end
      SZ_H: begin
        if (acc_lo_q[1]) load_ext = {{16{acc_sext_q & bus_rdata[31]}}, bus_rdata[31:16]};
        else             load_ext = {{16{acc_sext_q & bus_rdata[15]}}, bus_rdata[15:0]};
      end
      default: load_ext = bus_rdata;
    endcase
  end

  // Transaction FSM: launch, wait for ack or timeout, then one DONE cycle.
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    bus_err_d   = 1'b0;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    cnt_d       = cnt_q;
    acc_sz_d    = acc_sz_q;
    acc_sext_d  = acc_sext_q;
    acc_lo_d    = acc_lo_q;
    acc_fetch_d = acc_fetch_q;
    acc_irwr_d  = acc_irwr_q;
    case (state_q)
      S_IDLE: begin
        if (req && aligned) begin
          state_d     = S_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_wr;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_be_d    = mem_wr ? wr_be : 4'b1111;
          bus_wdata_d = mem_wr ? wr_data : '0;
          cnt_d       = '0;
          acc_sz_d    = sz;
          acc_sext_d  = sext;
          acc_lo_d    = addr[1:0];
          acc_fetch_d = ~ior_d;
          acc_irwr_d  = ir_wr;
        end
      end
      S_BUSY: begin
        if (bus_ack) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (!bus_we_q) begin
            if (acc_fetch_q) begin
              if (acc_irwr_q) ir_d = bus_rdata;
            end else begin
              mdr_d = load_ext;
            end
          end
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_DONE;
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      bus_err_q   <= 1'b0;
      ir_q        <= '0;
      mdr_q       <= '0;
      cnt_q       <= '0;
      acc_sz_q    <= SZ_W;
      acc_sext_q  <= 1'b0;
      acc_lo_q    <= '0;
      acc_fetch_q <= 1'b0;
      acc_irwr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      bus_err_q   <= bus_err_d;
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      cnt_q       <= cnt_d;
      acc_sz_q    <= acc_sz_d;
      acc_sext_q  <= acc_sext_d;
      acc_lo_q    <= acc_lo_d;
      acc_fetch_q <= acc_fetch_d;
      acc_irwr_q  <= acc_irwr_d;
    end
  end

  // IDLE stall/addr_err are combinational; both forced low while in reset.
  always_comb begin
    stall    = rst_n & (((state_q == S_IDLE) & req & aligned) | (state_q == S_BUSY));
    addr_err = rst_n & (state_q == S_IDLE) & req & ~aligned;
  end

  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign bus_err   = bus_err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, loads, stores, misalignment,
// ack timeout and reset during a transaction.
`timescale 1ns/1ps
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd, mem_wr, ior_d, ir_wr;
  logic [31:0] pc, alu_addr, store_data;
  logic        stall;
  logic [31:0] ir, mdr;
  logic        addr_err, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack;

  int tests = 0;
  int fails = 0;

  // Values observed by the access task for later checking.
  logic [31:0] o_addr, o_wdata, o_done_ir, o_done_mdr;
  logic [3:0]  o_be;
  logic        o_we, o_req, o_done_stall;
  int          o_stalls;
  int          n_busy;

  mem_access_unit #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .ior_d(ior_d), .ir_wr(ir_wr), .pc(pc), .alu_addr(alu_addr),
    .store_data(store_data), .stall(stall), .ir(ir), .mdr(mdr),
    .addr_err(addr_err), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one aligned access from IDLE; returns in the following IDLE cycle.
  task automatic access(input logic rd, input logic wr, input logic iord,
                        input logic irwr, input logic [31:0] pcv,
                        input logic [31:0] av, input logic [31:0] sd,
                        input int waits, input logic [31:0] rdata);
    mem_rd = rd; mem_wr = wr; ior_d = iord; ir_wr = irwr;
    pc = pcv; alu_addr = av; store_data = sd;
    o_stalls = 0;
    #1;
    if (stall) o_stalls++;
    tick();
    o_req = bus_req; o_we = bus_we; o_addr = bus_addr;
    o_be = bus_be; o_wdata = bus_wdata;
    for (int i = 0; i < waits; i++) begin
      if (stall) o_stalls++;
      tick();
    end
    if (stall) o_stalls++;
    bus_ack = 1'b1; bus_rdata = rdata;
    tick();
    bus_ack = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; ir_wr = 1'b0;
    o_done_stall = stall; o_done_ir = ir; o_done_mdr = mdr;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; ior_d = 1'b0; ir_wr = 1'b0;
    pc = '0; alu_addr = '0; store_data = '0; bus_rdata = '0; bus_ack = 1'b0;
    #2;
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_mdr", mdr, 32'd0);
    chk("rst_bus", {bus_req, bus_we, bus_be, addr_err, bus_err}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    mem_rd = 1'b0;
    #10 rst_n = 1'b1;
    tick();

    // Fetch at 0x100, zero-wait, loads an lb opcode into ir.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 0, 32'h8000_0000);
    chk("fetch_addr", o_addr, 32'h100);
    chk("fetch_req_we_be", {26'd0, o_req, o_we, o_be}, {26'd0, 1'b1, 1'b0, 4'hF});
    chk("fetch_stalls", o_stalls, 32'd2);
    chk("fetch_done_stall", {31'd0, o_done_stall}, 32'd0);
    chk("fetch_done_ir", o_done_ir, 32'h8000_0000);

    // lb at 0x203: top byte 0x80 sign-extended.
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h203, 32'h0, 0, 32'h80FF_FF12);
    chk("lb_addr", o_addr, 32'h200);
    chk("lb_mdr", o_done_mdr, 32'hFFFF_FF80);

    // lbu at the same address: zero-extended.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h0, 32'h0, 0, 32'h9000_0000);
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h203, 32'h0, 0, 32'h80FF_FF12);
    chk("lbu_mdr", mdr, 32'h0000_0080);

    // lh at 0x202 with 2 wait cycles: upper half sign-extended.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 32'h0, 32'h0, 0, 32'h8400_0000);
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h202, 32'h0, 2, 32'h8001_1234);
    chk("lh_mdr", mdr, 32'hFFFF_8001);
    chk("lh_stalls", o_stalls, 32'd4);

    // sh at 0x302: upper lanes, replicated half, mdr untouched.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h10C, 32'h0, 32'h0, 0, 32'hA400_0000);
    access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h302, 32'hDEAD_BEEF, 0, 32'h5555_5555);
    chk("sh_addr", o_addr, 32'h300);
    chk("sh_we_be", {27'd0, o_we, o_be}, {27'd0, 1'b1, 4'b1100});
    chk("sh_wdata", o_wdata, 32'hBEEF_BEEF);
    chk("sh_mdr_hold", mdr, 32'hFFFF_8001);

    // Fetch without ir_wr discards the data.
    access(1'b1, 1'b0, 1'b0, 1'b0, 32'h110, 32'h0, 32'h0, 0, 32'h1234_5678);
    chk("fetch_noirwr_ir", ir, 32'hA400_0000);

    // sb at 0x101: lane 1, replicated byte.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h114, 32'h0, 32'h0, 0, 32'hA000_0000);
    access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h101, 32'h1122_3344, 0, 32'h0);
    chk("sb_be", {28'd0, o_be}, 32'h2);
    chk("sb_wdata", o_wdata, 32'h4444_4444);

    // lw misaligned at 0x101: one-cycle addr_err, no bus cycle.
    access(1'b1, 1'b0, 1'b0, 1'b1, 32'h118, 32'h0, 32'h0, 0, 32'h8C00_0000);
    mem_rd = 1'b1; ior_d = 1'b1; alu_addr = 32'h101;
    #1;
    chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
    chk("mis_stall", {31'd0, stall}, 32'd0);
    tick();
    mem_rd = 1'b0;
    #1;
    chk("mis_pulse_end", {31'd0, addr_err}, 32'd0);
    chk("mis_no_req", {31'd0, bus_req}, 32'd0);
    tick();
    chk("mis_no_req2", {31'd0, bus_req}, 32'd0);
    chk("mis_mdr_hold", mdr, 32'hFFFF_8001);

    // lw aligned at 0x104 with 3 waits: unmodified word, 5 stall cycles.
    access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h104, 32'h0, 3, 32'hCAFE_F00D);
    chk("lw_mdr", mdr, 32'hCAFE_F00D);
    chk("lw_stalls", o_stalls, 32'd5);

    // Ack timeout: bus_err after 15 BUSY cycles.
    mem_rd = 1'b1; ior_d = 1'b1; alu_addr = 32'h108;
    tick();
    n_busy = 0;
    for (int i = 0; i < 40 && !bus_err; i++) begin
      if (bus_req) n_busy++;
      tick();
    end
    chk("to_err", {31'd0, bus_err}, 32'd1);
    chk("to_busy_cycles", n_busy, 32'd15);
    chk("to_req_stall", {30'd0, bus_req, stall}, 32'd0);
    mem_rd = 1'b0;
    tick();
    chk("to_err_pulse", {31'd0, bus_err}, 32'd0);
    chk("to_hold", mdr ^ ir, 32'hCAFE_F00D ^ 32'h8C00_0000);

    // Reset while BUSY after 3 wait cycles; a late ack is ignored.
    mem_rd = 1'b1; alu_addr = 32'h10C;
    tick(); tick(); tick(); tick();
    chk("rb_busy", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rb_req", {31'd0, bus_req}, 32'd0);
    chk("rb_stall", {31'd0, stall}, 32'd0);
    chk("rb_regs", bus_addr | ir | mdr, 32'd0);
    mem_rd = 1'b0;
    #3 rst_n = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    tick();
    chk("rb_late_ack", mdr | ir, 32'd0);
    chk("rb_late_req", {30'd0, bus_req, stall}, 32'd0);
    bus_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
